// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier.
// Holds the default operand/counter widths and the FSM state encoding.
package mul_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefCntW  = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier_4bit_if.sv
// Request/response bundle for the sequential multiplier.
//   start, a, b     : request side, driven by the master
//   busy, done      : status, driven by the multiplier
//   product         : registered 2*WIDTH-bit result
interface seq_multiplier_4bit_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, output a, output b,
                    input busy, input done, input product);
    modport slave  (input start, input a, input b,
                    output busy, output done, output product);
endinterface

// File: rtl/full_adder_4bit.sv
// Existing 4-bit ripple-carry adder.
//   sum   : 4-bit sum
//   c_out : carry out of bit 3
//   a, b  : addends
//   c_in  : carry into bit 0
module full_adder_4bit (
    output logic [3:0] sum,
    output logic       c_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in
);
    logic c1, c2, c3;

    assign sum[0] = a[0] ^ b[0] ^ c_in;
    assign c1     = (a[0] & b[0]) | (c_in & (a[0] ^ b[0]));
    assign sum[1] = a[1] ^ b[1] ^ c1;
    assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    assign sum[2] = a[2] ^ b[2] ^ c2;
    assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    assign sum[3] = a[3] ^ b[3] ^ c3;
    assign c_out  = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
endmodule

// File: rtl/seq_multiplier_4bit_add_nbit.sv
// WIDTH-bit adder used by the multiplier datapath.
//   sum   : WIDTH-bit sum
//   c_out : carry out of the MSB
//   a, b  : addends
//   c_in  : carry in
// At WIDTH=4 the existing 4-bit ripple adder is reused as-is.
module add_nbit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in
);
    if (WIDTH == 4) begin : g_fa4
        full_adder_4bit u_fa (
            .sum   (sum),
            .c_out (c_out),
            .a     (a),
            .b     (b),
            .c_in  (c_in)
        );
    end else begin : g_generic
        assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    end
endmodule

// File: rtl/seq_multiplier_4bit.sv
// Shift-and-add unsigned multiplier, one add per cycle, WIDTH cycles per product.
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset, discards any in-flight multiply
//   mul_if  : start/a/b request, busy/done status, registered product
module seq_multiplier_4bit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_multiplier_4bit_if.slave  mul_if
);
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 c_out;
    logic [WIDTH-1:0]     a_shift;
    logic [WIDTH-1:0]     q_shift;

    // Adding zero when Q[0]=0 yields {0,A}, so one adder path covers both cases.
    assign addend = q_q[0] ? m_q : '0;

    add_nbit #(
        .WIDTH (WIDTH)
    ) u_add (
        .sum   (sum),
        .c_out (c_out),
        .a     (a_q),
        .b     (addend),
        .c_in  (1'b0)
    );

    // {C,A,Q} >> 1: the carry lands in A's MSB, A's LSB moves into Q's MSB.
    assign a_shift = {c_out, sum[WIDTH-1:1]};
    assign q_shift = {sum[0], q_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
        case (state_q)
            StIdle, StDone: begin
                if (mul_if.start) begin
                    m_d     = mul_if.a;
                    q_d     = mul_if.b;
                    a_d     = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = StCalc;
                end else begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StCalc: begin
                a_d   = a_shift;
                q_d   = q_shift;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    prod_d  = {a_shift, q_shift};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign mul_if.busy    = busy_q;
    assign mul_if.done    = done_q;
    assign mul_if.product = prod_q;
endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Directed bench for seq_multiplier_4bit.
module tb_seq_multiplier_4bit;
    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    seq_multiplier_4bit_if #(.WIDTH(4)) mul_if ();

    seq_multiplier_4bit #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mul_if (mul_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Land 1 time unit after the rising edge: inputs change and outputs are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full multiply with latency, busy-length, single-pulse and result checks.
    task automatic do_mul(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] exp,
                          input string tag);
        int cycles;
        int busy_cnt;
        mul_if.a     = ta;
        mul_if.b     = tb;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(mul_if.busy), 32'd1);
        cycles   = 0;
        busy_cnt = 1;
        while (!mul_if.done && cycles < 12) begin
            step();
            cycles++;
            if (mul_if.busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd4);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({tag, "_product"}, 32'(mul_if.product), 32'(exp));
        step();
        check({tag, "_done_single"}, 32'(mul_if.done), 32'd0);
    endtask

    initial begin
        int pulses;
        int cycles;
        logic [7:0] seen;
        logic hold_ok;

        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        mul_if.start = 1'b0;
        mul_if.a     = '0;
        mul_if.b     = '0;
        step();
        step();
        check("reset_busy", 32'(mul_if.busy), 32'd0);
        check("reset_done", 32'(mul_if.done), 32'd0);
        check("reset_product", 32'(mul_if.product), 32'd0);
        reset = 1'b0;
        step();

        do_mul(4'd0, 4'd0, 8'h00, "zero");
        do_mul(4'd4, 4'd5, 8'h14, "m4x5");
        check("hold_idle", 32'(mul_if.product), 32'h14);
        do_mul(4'd10, 4'd6, 8'h3C, "m10x6");
        do_mul(4'd15, 4'd15, 8'hE1, "m15x15");

        // start pulsed mid-CALC must be ignored
        mul_if.a     = 4'd15;
        mul_if.b     = 4'd15;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        step();
        mul_if.a     = 4'd1;
        mul_if.b     = 4'd1;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        pulses = 0;
        seen   = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mul_if.done) begin
                pulses++;
                seen = mul_if.product;
            end
        end
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_product", 32'(seen), 32'hE1);

        // Back-to-back: start held during the DONE cycle
        mul_if.a     = 4'd15;
        mul_if.b     = 4'd15;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        cycles = 0;
        while (!mul_if.done && cycles < 12) begin
            step();
            cycles++;
        end
        check("b2b_first_done", 32'(mul_if.done), 32'd1);
        check("b2b_first_product", 32'(mul_if.product), 32'hE1);
        mul_if.a     = 4'd3;
        mul_if.b     = 4'd7;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        mul_if.a     = 4'd9;
        mul_if.b     = 4'd9;
        check("b2b_done_drop", 32'(mul_if.done), 32'd0);
        check("b2b_busy_rise", 32'(mul_if.busy), 32'd1);
        cycles  = 1;
        hold_ok = 1'b1;
        while (!mul_if.done && cycles < 12) begin
            if (mul_if.product !== 8'hE1) hold_ok = 1'b0;
            step();
            cycles++;
        end
        check("b2b_hold_first", 32'(hold_ok), 32'd1);
        check("b2b_latency", 32'(cycles), 32'd5);
        check("b2b_product", 32'(mul_if.product), 32'h15);
        step();

        // Asynchronous reset in the 2nd CALC cycle of 9x9
        mul_if.a     = 4'd9;
        mul_if.b     = 4'd9;
        mul_if.start = 1'b1;
        step();
        mul_if.start = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async_busy", 32'(mul_if.busy), 32'd0);
        check("async_done", 32'(mul_if.done), 32'd0);
        check("async_product", 32'(mul_if.product), 32'd0);
        step();
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mul_if.done) pulses++;
        end
        check("async_no_done", 32'(pulses), 32'd0);
        do_mul(4'd9, 4'd9, 8'h51, "m9x9");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_multiplier_4bit.md
Name: seq_multiplier_4bit

Overview:
- Sequential shift-and-add unsigned multiplier for the ALU/datapath.
- Consumes the team's ripple-carry adder: one add per cycle, WIDTH cycles per product.
- Takes two WIDTH-bit operands with a start/busy/done handshake and returns a 2*WIDTH-bit product.
- Sits alongside the adder in the execute stage; its result feeds the register-file write mux.

Parameters:
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, 3, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand; captured on the accepted start edge
- b  input  WIDTH  multiplier; captured on the accepted start edge
- busy  output  1  high while iterating (state CALC)
- done  output  1  one-cycle pulse: product is valid
- product  output  2*WIDTH  registered result; held until the next completion

Behaviour:
- Reset (asynchronous, active-high; also mid-operation):
  - state=IDLE; busy=0; done=0; product=0.
  - Internal M, A, Q, C and count cleared.
  - An in-flight multiply is discarded.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE:
  - start=1 at an edge -> M<=a, Q<=b, A<=0, C<=0, count<=WIDTH, state<=CALC, busy<=1.
  - start=0 -> stay in IDLE.
- CALC (one iteration per cycle):
  - If Q[0]=1: {C,A} <= A+M through the adder sub-module, c_in=0.
  - If Q[0]=0: {C,A} <= {0,A}.
  - Then {C,A,Q} shifts right by 1 within the same cycle; count decrements.
  - When count reaches 1 at an edge, that edge performs the last iteration, then: product <= {A,Q} (final value), done<=1, busy<=0, state<=DONE.
- DONE (one cycle, done=1):
  - start=1 -> accepted exactly as in IDLE; done drops and busy rises on that edge. This allows back-to-back operations.
  - start=0 -> IDLE, done<=0.
- Latency:
  - Accept edge E0; iterations at edges E1..EWIDTH.
  - done is high in the cycle after EWIDTH, i.e. WIDTH cycles after E0. WIDTH=4 gives done 4 cycles after start.
  - Throughput is one product per WIDTH+1 cycles.
- start while busy (CALC) is ignored: operands are not re-captured and the result is unaffected.
- a/b changes after the accept edge have no effect.
- The carry out of the add must be kept in C and shifted into A's MSB. No overflow is possible: the product always fits in 2*WIDTH bits.
- Operand zero still takes the full WIDTH iterations; there is no early exit.
- product holds its last value through IDLE and CALC. It updates only on the completion edge or on reset.

Decomposition:
- Shared package (mul_pkg) holds:
  - The state encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - The default WIDTH and CNT_W.
- Sub-module add_nbit:
  - WIDTH-bit ripple-carry adder with port order (sum, c_out, a, b, c_in), matching the existing 4-bit adder.
  - At WIDTH=4, the existing full_adder_4bit is instantiated directly.
- The FSM, counter and shift register live in the top module only.

Test Plan:
- Reset, then start with a=0, b=0 -> done pulses 4 cycles after start, product=0, busy high for exactly 4 cycles.
- a=4, b=5 -> product=20 (8'h14); then a=10, b=6 -> product=60 (8'h3C).
- a=15, b=15 -> product=225 (8'hE1); checks carry capture on every iteration.
- During a 15x15 operation, pulse start with a=1, b=1 at cycle 2 -> ignored; result still 225 and done pulses once.
- Start held high in the DONE cycle with a=3, b=7 -> second operation starts immediately; done pulses again 5 cycles later with product=21, and the first product stays visible until then.
- Assert reset in the 2nd CALC cycle of 9x9 -> busy=0, done=0 and product=0 immediately (asynchronous); no done pulse follows. A fresh 9x9 then yields 81.
